seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the stopwatch display driver.
- Samples the multiplexed seven-segment lines (cathode_in, anode_in) and reconstructs the four displayed digits, including blink blanking. Emits minutes/seconds binary values once per complete scan frame.
- Used as an on-board self-check and as the capture front end for a second board reading the display header.

---
 rtl/seg_scan_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan capture: rebuilds the four multiplexed digits from the
// display header lines and reports mm:ss once per complete scan frame.

module seg_digit_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_i,
   input  logic       blank_i,
   input  logic [3:0] val_i,
   output logic [3:0] digit_o,
   output logic       blank_o
);
   logic [3:0] digit_q, digit_d;
   logic       blank_q, blank_d;

   // A blank write keeps the last digit so blinking fields still report a value.
   always_comb begin
      digit_d = digit_q;
      blank_d = blank_q;
      if (wr_i) begin
         blank_d = blank_i;
         if (!blank_i) digit_d = val_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         digit_q <= '0;
         blank_q <= 1'b0;
      end else begin
         digit_q <= digit_d;
         blank_q <= blank_d;
      end
   end

   assign digit_o = digit_q;
   assign blank_o = blank_q;
endmodule

module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  cathode_in,
   input  logic [3:0]  anode_in,
   output logic [15:0] digit_bus,
   output logic [5:0]  minutes,
   output logic [5:0]  seconds,
   output logic [3:0]  blank_mask,
   output logic        frame_valid,
   output logic        decode_err,
   output logic        range_err,
   output logic        link_lost
);
   localparam int NUM_DIGITS = 4;
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);

   logic [10:0] sync1_q, sync2_q, prev_q;
   logic [6:0]  cath;
   logic [3:0]  anod;
   logic        changed, anode_chg;

   logic [SW-1:0] stab_q, stab_d;
   logic          armed_q, armed_d;
   logic          accept;

   logic        onehot;
   logic [1:0]  idx;
   logic        dec_hit, dec_blank;
   logic [3:0]  dec_val;

   logic [NUM_DIGITS-1:0]      wr;
   logic [NUM_DIGITS-1:0][3:0] digit;
   logic [NUM_DIGITS-1:0]      blank;
   logic [NUM_DIGITS-1:0]      seen_q, seen_d;

   logic [TW-1:0] idle_q, idle_d;
   logic          timeout_hit;

   logic [15:0] bus_q, bus_d;
   logic [5:0]  min_q, min_d, sec_q, sec_d;
   logic [3:0]  bmask_q, bmask_d;
   logic        fv_q, fv_d, derr_q, derr_d, rerr_q, rerr_d, lost_q, lost_d;

   function automatic logic [5:0] mmss(input logic [3:0] tens, input logic [3:0] ones);
      return 6'({tens, 3'b000}) + 6'({tens, 1'b0}) + 6'(ones);
   endfunction

   assign cath      = sync2_q[10:4];
   assign anod      = sync2_q[3:0];
   assign changed   = (sync2_q != prev_q);
   assign anode_chg = (sync2_q[3:0] != prev_q[3:0]);

   always_comb begin
      onehot = 1'b1;
      idx    = 2'd0;
      case (anod)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: onehot = 1'b0;
      endcase
   end

   always_comb begin
      dec_hit   = 1'b1;
      dec_blank = 1'b0;
      dec_val   = 4'd0;
      case (cath)
         7'h40: dec_val = 4'd0;
         7'h79: dec_val = 4'd1;
         7'h24: dec_val = 4'd2;
         7'h30: dec_val = 4'd3;
         7'h19: dec_val = 4'd4;
         7'h12: dec_val = 4'd5;
         7'h02: dec_val = 4'd6;
         7'h78: dec_val = 4'd7;
         7'h00: dec_val = 4'd8;
         7'h10: dec_val = 4'd9;
         7'h7F: dec_blank = 1'b1;
         default: dec_hit = 1'b0;
      endcase
   end

   // !changed guards the cycle where new data arrives while the count is still saturated.
   assign accept = (stab_q == STABLE_MAX) && !changed && armed_q && onehot;

   always_comb begin
      stab_d = changed ? '0 : ((stab_q == STABLE_MAX) ? stab_q : stab_q + 1'b1);
      armed_d = armed_q;
      if (accept)    armed_d = 1'b0;
      if (anode_chg) armed_d = 1'b1;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_slot
         assign wr[g] = accept && dec_hit && (idx == 2'(g));
         seg_digit_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (wr[g]),
            .blank_i (dec_blank),
            .val_i   (dec_val),
            .digit_o (digit[g]),
            .blank_o (blank[g])
         );
      end
   endgenerate

   assign timeout_hit = !accept && (idle_q == IDLE_LAST);

   always_comb begin
      idle_d = accept ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1);
      lost_d = accept ? 1'b0 : (lost_q | timeout_hit);

      // Clearing first lets an accept in the completion cycle seed the next frame.
      seen_d = seen_q;
      if (seen_q == 4'hF || timeout_hit) seen_d = '0;
      seen_d = seen_d | wr;

      fv_d    = (seen_q == 4'hF);
      derr_d  = accept && !dec_hit;
      bus_d   = bus_q;
      min_d   = min_q;
      sec_d   = sec_q;
      bmask_d = bmask_q;
      rerr_d  = rerr_q;
      if (seen_q == 4'hF) begin
         bus_d   = digit;
         min_d   = mmss(digit[3], digit[2]);
         sec_d   = mmss(digit[1], digit[0]);
         bmask_d = blank;
         rerr_d  = (digit[3] > 4'd5) || (digit[1] > 4'd5);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
         stab_q  <= '0;
         armed_q <= 1'b1;
         seen_q  <= '0;
         idle_q  <= '0;
         bus_q   <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         bmask_q <= '0;
         fv_q    <= 1'b0;
         derr_q  <= 1'b0;
         rerr_q  <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         sync1_q <= {cathode_in, anode_in};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         stab_q  <= stab_d;
         armed_q <= armed_d;
         seen_q  <= seen_d;
         idle_q  <= idle_d;
         bus_q   <= bus_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         bmask_q <= bmask_d;
         fv_q    <= fv_d;
         derr_q  <= derr_d;
         rerr_q  <= rerr_d;
         lost_q  <= lost_d;
      end
   end

   assign digit_bus   = bus_q;
   assign minutes     = min_q;
   assign seconds     = sec_q;
   assign blank_mask  = bmask_q;
   assign frame_valid = fv_q;
   assign decode_err  = derr_q;
   assign range_err   = rerr_q;
   assign link_lost   = lost_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of whole frames plus hand
// sequences for latency, glitching, re-arm, bad patterns, timeout and reset.

module tb_seg_scan_decoder;
   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
   localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
   localparam logic [6:0] SB = 7'h7F;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  cathode_in;
   logic [3:0]  anode_in;
   logic [15:0] digit_bus;
   logic [5:0]  minutes, seconds;
   logic [3:0]  blank_mask;
   logic        frame_valid, decode_err, range_err, link_lost;

   seg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
      .clk         (clk),
      .rst         (rst),
      .cathode_in  (cathode_in),
      .anode_in    (anode_in),
      .digit_bus   (digit_bus),
      .minutes     (minutes),
      .seconds     (seconds),
      .blank_mask  (blank_mask),
      .frame_valid (frame_valid),
      .decode_err  (decode_err),
      .range_err   (range_err),
      .link_lost   (link_lost)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int fv_cnt = 0;
   int de_cnt = 0;
   logic [15:0] cap_bus;
   logic [5:0]  cap_min, cap_sec;
   logic [3:0]  cap_blk;
   logic        cap_rerr;

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt++;
         cap_bus  = digit_bus;
         cap_min  = minutes;
         cap_sec  = seconds;
         cap_blk  = blank_mask;
         cap_rerr = range_err;
      end
      if (decode_err) de_cnt++;
   end

   typedef struct {
      logic [6:0]  c0, c1, c2, c3;
      logic [15:0] bus;
      logic [5:0]  mins, secs;
      logic [3:0]  blk;
      logic        rerr;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic dwell(input logic [3:0] an, input logic [6:0] ca, input int n);
      anode_in   = an;
      cathode_in = ca;
      repeat (n) @(negedge clk);
   endtask

   task automatic run_frame(input logic [6:0] c0, input logic [6:0] c1,
                            input logic [6:0] c2, input logic [6:0] c3);
      dwell(4'hE, c0, 200);
      dwell(4'hD, c1, 200);
      dwell(4'hB, c2, 200);
      dwell(4'h7, c3, 200);
   endtask

   task automatic chk_cap(input string nm, input logic [15:0] bus, input logic [5:0] mins,
                          input logic [5:0] secs, input logic [3:0] blk, input logic rerr);
      chk({nm, " digit_bus"},  cap_bus,  bus);
      chk({nm, " minutes"},    cap_min,  mins);
      chk({nm, " seconds"},    cap_sec,  secs);
      chk({nm, " blank_mask"}, cap_blk,  blk);
      chk({nm, " range_err"},  cap_rerr, rerr);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " digit_bus"},   digit_bus,   0);
      chk({nm, " minutes"},     minutes,     0);
      chk({nm, " seconds"},     seconds,     0);
      chk({nm, " blank_mask"},  blank_mask,  0);
      chk({nm, " frame_valid"}, frame_valid, 0);
      chk({nm, " decode_err"},  decode_err,  0);
      chk({nm, " range_err"},   range_err,   0);
      chk({nm, " link_lost"},   link_lost,   0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fv0, de0, n;
      tbl[0] = '{S4, S3, S2, S1, 16'h1234, 6'd12, 6'd34, 4'h0, 1'b0};
      tbl[1] = '{S9, S5, S5, S0, 16'h0559, 6'd5,  6'd59, 4'h0, 1'b0};
      tbl[2] = '{S9, S5, SB, SB, 16'h0559, 6'd5,  6'd59, 4'hC, 1'b0};
      tbl[3] = '{S0, S7, S0, S0, 16'h0070, 6'd0,  6'd6,  4'h0, 1'b1};
      tbl[4] = '{S6, S7, S8, S9, 16'h9876, 6'd34, 6'd12, 4'h0, 1'b1};
      tbl[5] = '{S0, S0, S0, S0, 16'h0000, 6'd0,  6'd0,  4'h0, 1'b0};

      rst = 1'b0;
      anode_in = 4'hF;
      cathode_in = SB;
      repeat (4) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         fv0 = fv_cnt;
         run_frame(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
         chk($sformatf("row%0d frame_valid pulses", i), fv_cnt - fv0, 1);
         chk_cap($sformatf("row%0d", i), tbl[i].bus, tbl[i].mins, tbl[i].secs,
                 tbl[i].blk, tbl[i].rerr);
      end

      // Latency from last digit's pin change to the frame_valid cycle.
      fv0 = fv_cnt;
      dwell(4'hE, S4, 200);
      dwell(4'hD, S3, 200);
      dwell(4'hB, S2, 200);
      anode_in = 4'h7;
      cathode_in = S1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_valid && n < 60);
      chk("latency to frame_valid", n, 21);
      repeat (200 - n) @(negedge clk);
      chk("latency frame count", fv_cnt - fv0, 1);
      chk("latency digit_bus", digit_bus, 16'h1234);

      // Cathode change under an unchanged anode must not re-accept.
      fv0 = fv_cnt;
      dwell(4'h7, S8, 100);
      dwell(4'hE, S0, 200);
      dwell(4'hD, S0, 200);
      dwell(4'hB, S0, 200);
      chk("rearm no frame", fv_cnt - fv0, 0);
      dwell(4'h7, S9, 200);
      chk("rearm frame count", fv_cnt - fv0, 1);
      chk_cap("rearm", 16'h9000, 6'd26, 6'd0, 4'h0, 1'b1);

      // Glitching cathode: no accept until a full stable run.
      fv0 = fv_cnt;
      dwell(4'hE, S5, 200);
      dwell(4'hD, S5, 200);
      dwell(4'hB, S4, 200);
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 1) dwell(4'h7, S2, 10);
         else            dwell(4'h7, S7, 10);
      end
      chk("glitch no frame", fv_cnt - fv0, 0);
      dwell(4'h7, S3, 200);
      chk("glitch frame count", fv_cnt - fv0, 1);
      chk_cap("glitch", 16'h3455, 6'd34, 6'd55, 4'h0, 1'b0);

      // Unrecognised pattern on seconds tens.
      fv0 = fv_cnt;
      de0 = de_cnt;
      dwell(4'hE, S0, 200);
      dwell(4'hD, 7'h7E, 200);
      dwell(4'hB, S1, 200);
      dwell(4'h7, S0, 200);
      chk("bad decode_err cycles", de_cnt - de0, 1);
      chk("bad no frame", fv_cnt - fv0, 0);
      dwell(4'hD, S5, 200);
      chk("bad frame count", fv_cnt - fv0, 1);
      chk_cap("bad", 16'h0150, 6'd1, 6'd50, 4'h0, 1'b0);

      // Timeout: partial frame, then idle anodes.
      fv0 = fv_cnt;
      dwell(4'hB, S1, 200);
      dwell(4'hD, S5, 200);
      dwell(4'hE, S0, 100);
      dwell(4'hF, S0, 919);
      chk("timeout before", link_lost, 1'b0);
      @(negedge clk);
      chk("timeout asserted", link_lost, 1'b1);
      repeat (50) @(negedge clk);
      chk("timeout held", link_lost, 1'b1);
      chk("timeout bus held", digit_bus, 16'h0150);
      dwell(4'h7, S2, 19);
      chk("lost before accept", link_lost, 1'b1);
      @(negedge clk);
      chk("lost cleared at accept", link_lost, 1'b0);
      repeat (180) @(negedge clk);
      chk("timeout seen cleared", fv_cnt - fv0, 0);
      dwell(4'hE, S7, 200);
      dwell(4'hD, S3, 200);
      dwell(4'hB, S4, 200);
      chk("post-timeout frame count", fv_cnt - fv0, 1);
      chk_cap("post-timeout", 16'h2437, 6'd24, 6'd37, 4'h0, 1'b0);

      // Reset mid-frame discards the partial frame.
      dwell(4'hE, S1, 200);
      dwell(4'hD, S1, 200);
      dwell(4'hB, S1, 200);
      fv0 = fv_cnt;
      rst = 1'b0;
      anode_in = 4'hF;
      repeat (3) @(negedge clk);
      chk_zero("midreset");
      rst = 1'b1;
      repeat (5) @(negedge clk);
      dwell(4'h7, S1, 200);
      chk("midreset no frame", fv_cnt - fv0, 0);
      chk("midreset bus", digit_bus, 16'h0000);
      dwell(4'hE, S1, 200);
      dwell(4'hD, S1, 200);
      dwell(4'hB, S1, 200);
      chk("midreset frame count", fv_cnt - fv0, 1);
      chk_cap("midreset", 16'h1111, 6'd11, 6'd11, 4'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
